hold_rr_arbiter: RTL and testbench
==================================

Name: hold_rr_arbiter

Overview:
- Parametrised successor to the combinational fixed-priority arbiter.
- Adds a runtime-selectable mode: fixed priority, with port 0 highest, or round-robin.
- Adds a registered one-hot grant that is held until the owner releases it, plus a hold-timeout counter for starvation protection.
- Sits between the per-row/per-port event request lines and the shared readout/serialiser path, which needs a stable owner for a multi-cycle transfer.

Parameters:
- NUM_PORTS, 4, number of requesters; legal range 2..64.
- MAX_HOLD, 16, maximum cycles one grant may be held before forced release; legal range 1..65535.
- IDX_W, $clog2(NUM_PORTS), width of the grant index (derived; do not override).
- CNT_W, $clog2(MAX_HOLD+1), width of the hold counter (derived).

Ports:
- clk_i  input  1  system clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- en_i  input  1  arbitration enable; when low, no new grant is issued.
- mode_i  input  1  0 = fixed priority (port 0 highest), 1 = round-robin.
- req_i  input  NUM_PORTS  request lines, level-sensitive.
- done_i  input  1  owner releases the grant (single-cycle pulse).
- gnt_o  output  NUM_PORTS  registered one-hot grant, all-zero when idle.
- gnt_idx_o  output  IDX_W  binary index of the granted port; valid while gnt_valid_o is high.
- gnt_valid_o  output  1  high while any grant is held (equals |gnt_o).
- timeout_o  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset values (asynchronous):
  - gnt_o = 0, gnt_idx_o = 0, gnt_valid_o = 0, timeout_o = 0.
  - Round-robin pointer ptr = 0, hold counter cnt = 0, state = IDLE.
- States: IDLE and GRANT.
- Selection function sel(vec):
  - Fixed mode: lowest set index of vec.
  - Round-robin mode: first set index at or above ptr, wrapping to 0. This uses the masked/unmasked double-pick method: masked pick when (vec & mask_ge_ptr) is nonzero, else the unmasked pick.
- IDLE:
  - If en_i && |req_i, then on the next edge gnt_o = onehot(sel(req_i)), gnt_idx_o is updated, state = GRANT, cnt = 1.
  - Grant latency is 1 cycle from the sampled request.
  - Otherwise stay in IDLE with outputs zero.
- GRANT, release condition rel = done_i || !req_i[gnt_idx_o] || (cnt == MAX_HOLD).
  - If !rel: hold gnt_o unchanged and increment cnt (saturating at MAX_HOLD).
  - If rel:
    - In round-robin mode, ptr = (gnt_idx_o + 1) mod NUM_PORTS; in fixed mode ptr is unchanged.
    - Candidate set = req_i & ~gnt_o, so the released port is excluded for this one decision.
    - If en_i and the candidate set is nonzero: back-to-back grant on the next edge with the new owner, cnt = 1, state stays GRANT. There is no idle bubble.
    - Else: gnt_o = 0 and state = IDLE.
  - timeout_o pulses for exactly the cycle after a release caused only by cnt == MAX_HOLD, i.e. with done_i low and the request still high.
- Simultaneous events:
  - done_i together with a timeout is a normal release; timeout_o stays low.
  - done_i while in IDLE is ignored.
- mode_i is sampled only at a grant decision (in IDLE or on a release cycle). A change in mid-grant has no effect on the current owner.
- en_i falling mid-grant: the current grant runs to release, then no new grant is issued.
- Invariants:
  - gnt_o is always one-hot or zero.
  - A grant is only issued to a port whose req_i was high in the decision cycle.
- MAX_HOLD = 1: every grant lasts exactly one cycle unless done_i arrives. This gives pure round-robin cycling.
- Reset asserted mid-grant: outputs clear immediately (asynchronously) and ptr returns to 0.

Decomposition:
- Package arb_pkg holds:
  - the state enum typedef (IDLE, GRANT);
  - a function onehot(idx) returning a NUM_PORTS vector;
  - a function lowest_set(vec) returning the index.
- Sub-module rr_pick (purely combinational): inputs req, ptr, mode; outputs one-hot pick and index. It is instantiated once.
- The top level owns the FSM, ptr, cnt and output registers.

Test Plan:
- All tests use NUM_PORTS=4.
- Fixed mode, MAX_HOLD=16, req_i=4'b1010, done_i pulsed 3 cycles after the grant → gnt_o=0010 one cycle after req, held 3 cycles; next cycle gnt_o=1000 back-to-back.
- Round-robin, all req_i=1111, done_i every 2nd cycle → grant order 0,1,2,3,0, each held 2 cycles, no idle gap; ptr wraps 3→0.
- Round-robin, req_i=0001 held, no done_i, MAX_HOLD=4 → gnt_o=0001 for 4 cycles; timeout_o pulses once; port 0 is excluded, so gnt_o=0 and IDLE; port 0 is re-granted on the following cycle.
- Requester drops: gnt on port 2, req_i[2] falls while req_i[1]=1 → next edge gnt_o=0010, with no done_i needed.
- en_i=0 with req_i=1111 → gnt_o stays 0. Raise en_i mid-run, then drop en_i during a grant → grant completes on done_i, then gnt_o=0.
- Reset mid-grant (gnt_o=0100, ptr=3) → gnt_o=0 asynchronously. After reset, round-robin with req_i=1111 grants port 0 first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and index helpers for the hold/round-robin arbiter.
// Helpers work on a 64-bit canvas so any legal port count can slice its own width.
package arb_pkg;

  localparam int MAX_PORTS = 64;
  localparam int MAX_IDX_W = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [MAX_PORTS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_PORTS-1:0] vec;
    vec      = {MAX_PORTS{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Scans from the top so the last hit is the lowest set bit.
  function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [MAX_PORTS-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = {MAX_IDX_W{1'b0}};
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = MAX_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/hold_rr_arbiter_rr_pick.sv
// Combinational selector: lowest requester in fixed mode, first requester
// at or above ptr (wrapping) in round-robin mode via a masked/unmasked double pick.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  input  logic                 mode_i,
  output logic [NUM_PORTS-1:0] pick_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [NUM_PORTS-1:0] mask_ge_s;
  logic [NUM_PORTS-1:0] masked_s;
  logic [NUM_PORTS-1:0] src_s;
  logic [MAX_IDX_W-1:0] idx_full_s;
  logic [MAX_PORTS-1:0] oh_full_s;
  logic                 unused_s;

  // Thermometer mask of ports at or above the pointer
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      mask_ge_s[i] = (IDX_W'(i) >= ptr_i);
    end
  end

  assign masked_s = req_i & mask_ge_s;

  // Fall back to the unmasked vector when nothing sits at or above ptr
  always_comb begin
    if (mode_i && (masked_s != {NUM_PORTS{1'b0}})) begin
      src_s = masked_s;
    end else begin
      src_s = req_i;
    end
  end

  assign idx_full_s = lowest_set(MAX_PORTS'(src_s));
  assign oh_full_s  = onehot(idx_full_s);
  assign idx_o      = idx_full_s[IDX_W-1:0];
  assign pick_o     = oh_full_s[NUM_PORTS-1:0] & req_i;
  assign unused_s   = (^oh_full_s) ^ (^idx_full_s);

endmodule

// File: rtl/hold_rr_arbiter.sv
// Arbiter with a registered one-hot grant held until release (done, request
// drop or MAX_HOLD timeout), selectable fixed-priority or round-robin.
module hold_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 16,
  parameter int IDX_W     = $clog2(NUM_PORTS),
  parameter int CNT_W     = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic                 mode_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 done_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 gnt_valid_o,
  output logic                 timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PORTS - 1);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 to_q, to_d;

  logic [NUM_PORTS-1:0] cand_s, pick_s;
  logic [IDX_W-1:0]     pick_idx_s, ptr_next_s, ptr_sel_s;
  logic                 own_req_s, at_max_s, rel_s;

  assign ptr_next_s = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
  assign own_req_s  = req_i[idx_q];
  assign at_max_s   = (cnt_q == CNT_MAX);
  assign rel_s      = done_i || !own_req_s || at_max_s;

  // On a release decision the outgoing owner is masked off and the advanced pointer is used
  always_comb begin
    if (state_q == GRANT) begin
      cand_s    = req_i & ~gnt_q;
      ptr_sel_s = ptr_next_s;
    end else begin
      cand_s    = req_i;
      ptr_sel_s = ptr_q;
    end
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req_i  (cand_s),
    .ptr_i  (ptr_sel_s),
    .mode_i (mode_i),
    .pick_o (pick_s),
    .idx_o  (pick_idx_s)
  );

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && (req_i != {NUM_PORTS{1'b0}})) begin
          state_d = GRANT;
          gnt_d   = pick_s;
          idx_d   = pick_idx_s;
          cnt_d   = CNT_ONE;
          valid_d = 1'b1;
        end else begin
          gnt_d   = {NUM_PORTS{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (rel_s) begin
          to_d = at_max_s && !done_i && own_req_s;
          if (mode_i) begin
            ptr_d = ptr_next_s;
          end else begin
            ptr_d = ptr_q;
          end
          if (en_i && (cand_s != {NUM_PORTS{1'b0}})) begin
            gnt_d   = pick_s;
            idx_d   = pick_idx_s;
            cnt_d   = CNT_ONE;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = {NUM_PORTS{1'b0}};
            idx_d   = {IDX_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = at_max_s ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {NUM_PORTS{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      gnt_q   <= {NUM_PORTS{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      ptr_q   <= {IDX_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_hold_rr_arbiter.sv
// Scoreboard bench: each driven cycle queues the outputs expected after the
// next rising edge; a monitor pops and compares them just after that edge.
module tb_hold_rr_arbiter;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       en_i;
  logic       mode_i;
  logic       done_i;
  logic [3:0] req_i;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b, to_a, to_b;

  typedef struct packed {
    logic [3:0] gnt;
    logic       to;
    logic       use4;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;
  string cur_test = "reset";

  logic [3:0] m_gnt;
  logic [1:0] m_idx;
  logic       m_vld, m_to;

  hold_rr_arbiter #(.NUM_PORTS(4), .MAX_HOLD(16)) dut16 (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .mode_i(mode_i),
    .req_i(req_i), .done_i(done_i), .gnt_o(gnt_a), .gnt_idx_o(idx_a),
    .gnt_valid_o(vld_a), .timeout_o(to_a)
  );

  hold_rr_arbiter #(.NUM_PORTS(4), .MAX_HOLD(4)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .mode_i(mode_i),
    .req_i(req_i), .done_i(done_i), .gnt_o(gnt_b), .gnt_idx_o(idx_b),
    .gnt_valid_o(vld_b), .timeout_o(to_b)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Apply one cycle of stimulus and queue what the DUT must show after the next edge
  task automatic drive(input logic [3:0] req, input logic done, input logic en,
                       input logic mode, input logic [3:0] exp_gnt,
                       input logic exp_to, input logic use4);
    exp_t e;
    req_i  = req;
    done_i = done;
    en_i   = en;
    mode_i = mode;
    e.gnt  = exp_gnt;
    e.to   = exp_to;
    e.use4 = use4;
    sb_q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    req_i   = 4'b0000;
    done_i  = 1'b0;
    en_i    = 1'b0;
    mode_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  always @(posedge clk_i) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.use4) begin
        m_gnt = gnt_b; m_idx = idx_b; m_vld = vld_b; m_to = to_b;
      end else begin
        m_gnt = gnt_a; m_idx = idx_a; m_vld = vld_a; m_to = to_a;
      end
      check_eq({cur_test, ".gnt"},   32'(m_gnt), 32'(mon_e.gnt));
      check_eq({cur_test, ".idx"},   32'(m_idx), 32'(idx_of(mon_e.gnt)));
      check_eq({cur_test, ".valid"}, 32'(m_vld), 32'(|mon_e.gnt));
      check_eq({cur_test, ".tmo"},   32'(m_to),  32'(mon_e.to));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    reset_i = 1'b1;
    en_i    = 1'b0;
    mode_i  = 1'b0;
    done_i  = 1'b0;
    req_i   = 4'b0000;
    repeat (2) @(negedge clk_i);
    check_eq("rst.gnt16", 32'(gnt_a), 32'd0);
    check_eq("rst.idx16", 32'(idx_a), 32'd0);
    check_eq("rst.vld16", 32'(vld_a), 32'd0);
    check_eq("rst.to16",  32'(to_a),  32'd0);
    check_eq("rst.gnt4",  32'(gnt_b), 32'd0);
    check_eq("rst.to4",   32'(to_b),  32'd0);
    reset_i = 1'b0;

    // Fixed priority, hold until done then back-to-back handover
    cur_test = "fixed";
    drive(4'b1010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    drive(4'b1010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    drive(4'b1010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    drive(4'b1010, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    do_reset();

    // Round-robin rotation with wrap 3 -> 0
    cur_test = "rr";
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    do_reset();

    // MAX_HOLD=4 timeout, re-grant, then done coinciding with the limit
    cur_test = "timeout";
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(4'b0001, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    do_reset();

    // Owner drops its request; fixed mode picks lowest on handover
    cur_test = "drop";
    drive(4'b0100, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    drive(4'b0110, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    drive(4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    drive(4'b0101, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    do_reset();

    // Enable gating: nothing while low, grant runs to done after en falls
    cur_test = "enable";
    drive(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    do_reset();

    // Build gnt=0100 with ptr=3, then reset asynchronously mid-cycle
    cur_test = "midrst";
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0);
    drive(4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0);
    drive(4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0);
    #2;
    reset_i = 1'b1;
    #1;
    check_eq("midrst.async_gnt", 32'(gnt_a), 32'd0);
    check_eq("midrst.async_vld", 32'(vld_a), 32'd0);
    check_eq("midrst.async_idx", 32'(idx_a), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);

    @(negedge clk_i);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
